// File: rtl/nibble_selector_stream.sv
// Per-lane nibble selector with valid/ready flow control and a scan mode that
// walks every lane's nibble index across NIBS beats for a single request.
module nibble_selector_stream #(
   parameter  int DATA_W = 32,
   parameter  int NIB_W  = 4,
   parameter  int LANES  = 4,
   localparam int NIBS   = DATA_W / NIB_W,
   localparam int IDX_W  = $clog2(NIBS)
) (
   input  logic                     CLK,
   input  logic                     RESET_L,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [DATA_W-1:0]        DATA_A,
   input  logic [DATA_W-1:0]        DATA_B,
   input  logic [LANES*IDX_W-1:0]   SL_SEL_A,
   input  logic [LANES*IDX_W-1:0]   SL_SEL_B,
   input  logic [LANES-1:0]         SL_SEL,
   input  logic                     SCAN_MODE,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [LANES*NIB_W-1:0]   NIBBLE_OUT,
   output logic [IDX_W-1:0]         OUT_BEAT,
   output logic                     OUT_LAST,
   output logic                     dbg_state
);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; the output register may be reloaded in that same cycle.
   state_t                   state, state_d;
   logic [IDX_W-1:0]         cnt, cnt_d;
   logic [DATA_W-1:0]        hold_a, hold_a_d, hold_b, hold_b_d;
   logic [LANES*IDX_W-1:0]   hold_sa, hold_sa_d, hold_sb, hold_sb_d;
   logic [LANES-1:0]         hold_sel, hold_sel_d;
   logic                     valid_d, last_d;
   logic [LANES*NIB_W-1:0]   nib_d;
   logic [IDX_W-1:0]         beat_d;
   logic                     out_free, accept;

   function automatic logic [LANES*NIB_W-1:0] pick(
      input logic [DATA_W-1:0]      a,
      input logic [DATA_W-1:0]      b,
      input logic [LANES*IDX_W-1:0] sa,
      input logic [LANES*IDX_W-1:0] sb,
      input logic [LANES-1:0]       s,
      input logic [IDX_W-1:0]       k
   );
      logic [LANES*NIB_W-1:0] r;
      logic [IDX_W-1:0]       idx;
      logic [DATA_W-1:0]      src;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         src = s[i] ? b : a;
         // IDX_W-bit add gives the wrap-around for free
         idx = (s[i] ? sb[i*IDX_W +: IDX_W] : sa[i*IDX_W +: IDX_W]) + k;
         r[i*NIB_W +: NIB_W] = src[int'(idx)*NIB_W +: NIB_W];
      end
      return r;
   endfunction

   assign out_free  = !OUT_VALID || OUT_READY;
   assign IN_READY  = RESET_L && (state == IDLE) && out_free;
   assign accept    = IN_VALID && IN_READY;
   assign dbg_state = state;

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      hold_a_d   = hold_a;
      hold_b_d   = hold_b;
      hold_sa_d  = hold_sa;
      hold_sb_d  = hold_sb;
      hold_sel_d = hold_sel;
      valid_d    = OUT_VALID;
      last_d     = OUT_LAST;
      nib_d      = NIBBLE_OUT;
      beat_d     = OUT_BEAT;
      case (state)
         IDLE: begin
            if (accept) begin
               nib_d   = pick(DATA_A, DATA_B, SL_SEL_A, SL_SEL_B, SL_SEL, '0);
               valid_d = 1'b1;
               beat_d  = '0;
               last_d  = !SCAN_MODE;
               if (SCAN_MODE) begin
                  hold_a_d   = DATA_A;
                  hold_b_d   = DATA_B;
                  hold_sa_d  = SL_SEL_A;
                  hold_sb_d  = SL_SEL_B;
                  hold_sel_d = SL_SEL;
                  cnt_d      = IDX_W'(1);
                  state_d    = SCAN;
               end
            end else if (OUT_READY) begin
               valid_d = 1'b0;
            end
         end
         SCAN: begin
            if (out_free) begin
               nib_d   = pick(hold_a, hold_b, hold_sa, hold_sb, hold_sel, cnt);
               valid_d = 1'b1;
               beat_d  = cnt;
               last_d  = (cnt == LAST_IDX);
               cnt_d   = cnt + 1'b1;
               if (cnt == LAST_IDX) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state      <= IDLE;
         cnt        <= '0;
         hold_a     <= '0;
         hold_b     <= '0;
         hold_sa    <= '0;
         hold_sb    <= '0;
         hold_sel   <= '0;
         OUT_VALID  <= 1'b0;
         OUT_LAST   <= 1'b0;
         NIBBLE_OUT <= '0;
         OUT_BEAT   <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         hold_a     <= hold_a_d;
         hold_b     <= hold_b_d;
         hold_sa    <= hold_sa_d;
         hold_sb    <= hold_sb_d;
         hold_sel   <= hold_sel_d;
         OUT_VALID  <= valid_d;
         OUT_LAST   <= last_d;
         NIBBLE_OUT <= nib_d;
         OUT_BEAT   <= beat_d;
      end
   end

endmodule

// File: doc/nibble_selector_stream.md
Name: nibble_selector_stream

Overview:
- Parametrised, handshaked successor of the 4-lane nibble selector.
- LANES independent lanes each pick one NIB_W-bit nibble from DATA_A or DATA_B and drive a registered output word.
- Adds valid/ready flow control with backpressure.
- Adds a scan mode: one accepted input produces NIBS output beats, each lane's nibble index advancing by one per beat with wrap-around.
- Sits between the data sources and the downstream nibble consumer/serialiser.

Parameters:
- DATA_W, 32, width of DATA_A/DATA_B. Must be a multiple of NIB_W.
- NIB_W, 4, nibble width.
- LANES, 4, number of output lanes.
- NIBS, DATA_W/NIB_W (derived, localparam), nibbles per source word. Must be a power of 2, at least 2.
- IDX_W, $clog2(NIBS) (derived, localparam), nibble index width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_L  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  input request valid.
- IN_READY  out  1  block can accept an input this cycle.
- DATA_A  in  DATA_W  source word A.
- DATA_B  in  DATA_W  source word B.
- SL_SEL_A  in  LANES*IDX_W  per-lane nibble index into A; lane i uses bits [i*IDX_W +: IDX_W].
- SL_SEL_B  in  LANES*IDX_W  per-lane nibble index into B; same packing.
- SL_SEL  in  LANES  per-lane source: 1 = B, 0 = A.
- SCAN_MODE  in  1  0 = direct (1 beat per input), 1 = scan (NIBS beats per input).
- OUT_VALID  out  1  NIBBLE_OUT valid.
- OUT_READY  in  1  downstream accepts the output.
- NIBBLE_OUT  out  LANES*NIB_W  lane i at bits [i*NIB_W +: NIB_W].
- OUT_BEAT  out  IDX_W  beat number of the current output; 0 in direct mode.
- OUT_LAST  out  1  last beat of the current request; always 1 in direct mode.

Behaviour:
- Reset (RESET_L low, asynchronous):
  - OUT_VALID = 0, NIBBLE_OUT = 0, OUT_BEAT = 0, OUT_LAST = 0.
  - FSM goes to IDLE, beat counter = 0, hold registers = 0.
  - IN_READY forced to 0 while RESET_L is low.
- Definitions:
  - out_free = !OUT_VALID || OUT_READY.
  - Output transfer = OUT_VALID && OUT_READY.
  - Input accept = IN_VALID && IN_READY.
- Beat k selection, lane i:
  - src = SL_SEL[i] ? B : A.
  - idx = (sel_src[i] + k) mod NIBS; wrap-around is implicit in IDX_W-bit addition.
  - Lane value = src[idx*NIB_W +: NIB_W].
- FSM IDLE:
  - IN_READY = out_free.
  - Accept with SCAN_MODE = 0: load output register with beat 0 (k = 0) from live inputs. OUT_VALID = 1, OUT_BEAT = 0, OUT_LAST = 1. Stay in IDLE.
  - Accept with SCAN_MODE = 1: capture DATA_A, DATA_B, SL_SEL_A, SL_SEL_B, SL_SEL into hold registers. Load beat 0 (OUT_LAST = 0), set counter = 1, go to SCAN.
  - No accept and OUT_READY = 1: OUT_VALID clears to 0 next cycle.
- FSM SCAN:
  - IN_READY = 0.
  - When out_free: load beat = counter from hold registers, set OUT_BEAT = counter, OUT_VALID = 1, increment counter.
  - On counter == NIBS-1: OUT_LAST = 1, counter resets to 0, go to IDLE.
  - Inputs changing during SCAN have no effect.
- Latency and throughput:
  - Latency is 1 cycle from accept to OUT_VALID.
  - Throughput is 1 beat per cycle when OUT_READY is held at 1, including direct mode back-to-back and IDLE re-accept in the cycle after the last scan beat is transferred.
- Backpressure: while OUT_VALID && !OUT_READY, NIBBLE_OUT, OUT_BEAT and OUT_LAST hold stable, and no beat is dropped or skipped.
- Simultaneous events: output transfer and new load in the same cycle is allowed; the register is overwritten with the new beat.
- Reset mid-scan aborts the request; remaining beats are discarded.
- Combinational paths:
  - IN_READY is combinational from OUT_VALID/OUT_READY/state.
  - No combinational path from IN_VALID to OUT_VALID.

Test Plan:
- Reset value check (default params): assert RESET_L = 0 mid-stream -> OUT_VALID = 0, NIBBLE_OUT = 16'h0000, IN_READY = 0 immediately, without waiting for a clock edge.
- Direct, source A: DATA_A = 32'h76543210, DATA_B = 32'hFEDCBA98, SL_SEL = 4'b0000, SL_SEL_A = 12'h688, SCAN_MODE = 0, OUT_READY = 1 -> one cycle later NIBBLE_OUT = 16'h3210, OUT_LAST = 1, OUT_BEAT = 0.
- Direct, mixed sources: same data, SL_SEL = 4'b1010, SL_SEL_B = 12'hFFF -> NIBBLE_OUT = 16'hF2F0. Three back-to-back inputs give three consecutive OUT_VALID cycles.
- Scan: DATA_A = 32'h76543210, SL_SEL = 0, SL_SEL_A = 12'h688, SCAN_MODE = 1 -> 8 beats 16'h3210, 16'h4321, … , 16'h0765, 16'h1076, 16'h2107. OUT_BEAT runs 0..7, OUT_LAST = 1 only on 16'h2107, IN_READY = 0 throughout. Changing DATA_A after accept has no effect on the beats.
- Backpressure: in scan, drop OUT_READY for 3 cycles at beat 2 -> NIBBLE_OUT held at 16'h5432 with OUT_BEAT = 2. Remaining beats are in order with none lost, 8 transfers total.
- Reset mid-scan: pulse RESET_L low after beat 4 transfers -> outputs clear, FSM returns to IDLE. A new direct request then produces a correct single beat with OUT_BEAT = 0.
